unita_conv_ctrl: RTL

//  Sequencer for one unitA_5 convolution unit. Per (filter, depth-slice) it loads KERNAL_SIZE^2 weights

---
 rtl/unita_ctrl_pkg.sv | 31 +++
 rtl/unita_window_tracker.sv | 48 ++++
 rtl/unita_conv_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/unita_ctrl_pkg.sv
// Shared types and sizing helpers for the unitA_5 convolution controller.
// WIN and CEIL_DEPTH describe the default layer; instances re-derive them from their own parameters.
package unita_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        NEXT,
        FINISH
    } state_t;

    // Ceiling division used for the per-unit depth share.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IFM_DEPTH       = 30;
    localparam int unsigned DEF_KERNAL_SIZE     = 5;
    localparam int unsigned DEF_NUMBER_OF_UNITS = 3;

    localparam int unsigned WIN        = DEF_KERNAL_SIZE * DEF_KERNAL_SIZE;
    localparam int unsigned CEIL_DEPTH = ceil_div(DEF_IFM_DEPTH, DEF_NUMBER_OF_UNITS);

endpackage

// File: rtl/unita_window_tracker.sv
// Raster row/col tracker for one IFM slice; flags the beat that completes a KxK window
// and the final beat of the slice.
module unita_window_tracker
    import unita_ctrl_pkg::*;
#(
    parameter int unsigned IFM_SIZE    = 5,
    parameter int unsigned KERNAL_SIZE = 5,
    localparam int unsigned POS_W      = cnt_w(IFM_SIZE)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic beat,
    output logic win_done_c,
    output logic last_beat_c
);

    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;

    logic col_last;
    logic row_last;

    assign col_last = (col == POS_W'(IFM_SIZE - 1));
    assign row_last = (row == POS_W'(IFM_SIZE - 1));

    // A window is complete once both coordinates reach the kernel's bottom-right corner.
    assign win_done_c  = beat && (row >= POS_W'(KERNAL_SIZE - 1)) && (col >= POS_W'(KERNAL_SIZE - 1));
    assign last_beat_c = beat && row_last && col_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (beat) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + POS_W'(1);
            end else begin
                col <= col + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/unita_conv_ctrl.sv
// Sequencer for one unitA_5 convolution unit: weight load, IFM stream, drain, per (filter, depth) slice.
// Optional UNITA_CTRL_PERF_EN adds perf_stall_cycles (STREAM cycles with ifm_valid low).
module unita_conv_ctrl
    import unita_ctrl_pkg::*;
#(
    parameter int unsigned IFM_SIZE          = 5,
    parameter int unsigned IFM_DEPTH         = 30,
    parameter int unsigned KERNAL_SIZE       = 5,
    parameter int unsigned NUMBER_OF_FILTERS = 100,
    parameter int unsigned NUMBER_OF_UNITS   = 3,
    parameter int unsigned CONV_LATENCY      = 4,
    localparam int unsigned C_DEPTH          = ceil_div(IFM_DEPTH, NUMBER_OF_UNITS),
    localparam int unsigned K_WIN            = KERNAL_SIZE * KERNAL_SIZE,
    localparam int unsigned ADDRESS_SIZE_WM  = cnt_w(K_WIN * NUMBER_OF_FILTERS * C_DEPTH),
    localparam int unsigned FILTER_W         = cnt_w(NUMBER_OF_FILTERS),
    localparam int unsigned DEPTH_W          = cnt_w(C_DEPTH),
    localparam int unsigned RD_W             = cnt_w(K_WIN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       ifm_valid,
    output logic                       ifm_ready,
    output logic                       fifo_enable,
    output logic                       wm_enable_read,
    output logic                       wm_enable_write,
    output logic [ADDRESS_SIZE_WM-1:0] wm_address,
    output logic                       wm_fifo_enable,
    output logic                       conv_enable,
    output logic                       out_valid,
    output logic [FILTER_W-1:0]        filter_idx,
    output logic [DEPTH_W-1:0]         depth_idx
`ifdef UNITA_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles
`endif
);

    state_t state;
    state_t state_nxt;

    logic                       restart;
    logic                       rd_issue;
    logic                       last_slice;
    logic                       pipe_empty;
    logic                       win_done_c;
    logic                       last_beat_c;
    logic [RD_W-1:0]            rd_cnt;
    logic [ADDRESS_SIZE_WM-1:0] next_addr;
    logic [CONV_LATENCY-1:0]    ov_pipe;

    assign wm_enable_write = 1'b0;
    assign fifo_enable     = ifm_valid & ifm_ready;
    assign out_valid       = ov_pipe[CONV_LATENCY-1];

    assign last_slice = (filter_idx == FILTER_W'(NUMBER_OF_FILTERS - 1)) &&
                        (depth_idx == DEPTH_W'(C_DEPTH - 1));
    assign pipe_empty = !conv_enable && (ov_pipe == '0);

    unita_window_tracker #(
        .IFM_SIZE    (IFM_SIZE),
        .KERNAL_SIZE (KERNAL_SIZE)
    ) u_window_tracker (
        .clk         (clk),
        .reset       (reset),
        .clear       (restart),
        .beat        (fifo_enable),
        .win_done_c  (win_done_c),
        .last_beat_c (last_beat_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the read-issue strobe; the first read of a slice is issued on LOAD_W entry.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_W;
                    restart   = 1'b1;
                    rd_issue  = 1'b1;
                end
            end
            LOAD_W: begin
                if (wm_enable_read && (rd_cnt != RD_W'(K_WIN))) begin
                    rd_issue = 1'b1;
                end
                if (wm_fifo_enable && !wm_enable_read) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (last_beat_c) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (last_slice) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = LOAD_W;
                    rd_issue  = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ifm_ready <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE) && (state_nxt != FINISH);
            done      <= (state_nxt == FINISH);
            ifm_ready <= (state_nxt == STREAM);
        end
    end

    // Slices are visited in address order, so the weight address simply keeps counting across slices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wm_enable_read <= 1'b0;
            wm_fifo_enable <= 1'b0;
            wm_address     <= '0;
            next_addr      <= '0;
            rd_cnt         <= '0;
        end else begin
            wm_enable_read <= rd_issue;
            wm_fifo_enable <= wm_enable_read;
            if (rd_issue) begin
                wm_address <= restart ? '0 : next_addr;
                next_addr  <= restart ? ADDRESS_SIZE_WM'(1) : next_addr + ADDRESS_SIZE_WM'(1);
                rd_cnt     <= (state == LOAD_W) ? rd_cnt + RD_W'(1) : RD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_idx <= '0;
            depth_idx  <= '0;
        end else if (restart) begin
            filter_idx <= '0;
            depth_idx  <= '0;
        end else if ((state == NEXT) && !last_slice) begin
            if (depth_idx == DEPTH_W'(C_DEPTH - 1)) begin
                depth_idx  <= '0;
                filter_idx <= filter_idx + FILTER_W'(1);
            end else begin
                depth_idx  <= depth_idx + DEPTH_W'(1);
            end
        end
    end

    // conv_enable trails the window-completing beat by one cycle; out_valid trails it by CONV_LATENCY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_enable <= 1'b0;
            ov_pipe     <= '0;
        end else begin
            conv_enable <= win_done_c;
            ov_pipe[0]  <= conv_enable;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                ov_pipe[i] <= ov_pipe[i-1];
            end
        end
    end

`ifdef UNITA_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (restart) begin
            perf_stall_cycles <= '0;
        end else if ((state == STREAM) && !ifm_valid && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
